// File: rtl/burst_line_adaptor_pkg.sv
// rtl/burst_line_adaptor_pkg.sv - shared FSM state type and beat index sizing for burst_line_adaptor
package burst_line_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  // Width of a beat index for a line of line_w bits split into burst_w-bit beats.
  function automatic int beat_idx_w(input int line_w, input int burst_w);
    return (line_w / burst_w > 1) ? $clog2(line_w / burst_w) : 1;
  endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// rtl/burst_beat_counter.sv - beat slot index with loadable start and a start-independent last-beat flag
module burst_beat_counter
  import burst_line_adaptor_pkg::*;
#(
  parameter int BEATS = 4,
  localparam int IDX_W = beat_idx_w(BEATS, 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [IDX_W-1:0] start,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] cnt;

  // idx wraps naturally because BEATS is a power of two; cnt tracks beats done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (load) begin
      idx <= start;
      cnt <= '0;
    end else if (en) begin
      idx <= idx + 1'b1;
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == IDX_W'(BEATS - 1));

endmodule

// File: rtl/burst_line_adaptor.sv
// rtl/burst_line_adaptor.sv - cache line to memory burst bridge; BURST_LINE_ADAPTOR_CWF_EN enables critical-word-first reads
module burst_line_adaptor
  import burst_line_adaptor_pkg::*;
#(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int IDX_W = beat_idx_w(LINE_W, BURST_W);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  state_t            state;
  logic [LINE_W-1:0] line_q;
  logic [IDX_W-1:0]  beat_idx;
  logic [IDX_W-1:0]  beat_nxt;
  logic [IDX_W-1:0]  rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic              beat_last;
  logic              cnt_load;
  logic              cnt_en;

`ifdef BURST_LINE_ADAPTOR_CWF_EN
  localparam int LINE_OFF = $clog2(LINE_W / 8);
  localparam int BEAT_OFF = $clog2(BURST_W / 8);
  localparam logic [ADDR_W-1:0] BEAT_MASK = ~ADDR_W'(BURST_W / 8 - 1);

  assign rd_addr  = address_i & BEAT_MASK;
  assign rd_start = address_i[LINE_OFF-1:BEAT_OFF];
`else
  assign rd_addr  = address_i & LINE_MASK;
  assign rd_start = '0;
`endif

  assign cnt_load = (state == IDLE) && (read_i || write_i);
  assign cnt_en   = ((state == RD) || (state == WR)) && resp_i;
  assign beat_nxt = beat_idx + 1'b1;

  burst_beat_counter #(
    .BEATS(BEATS)
  ) u_beat_counter (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (cnt_load),
    .start  (read_i ? rd_start : '0),
    .en     (cnt_en),
    .idx    (beat_idx),
    .last   (beat_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      line_q    <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_i) begin
            state     <= RD;
            read_o    <= 1'b1;
            address_o <= rd_addr;
          end else if (write_i) begin
            state     <= WR;
            write_o   <= 1'b1;
            address_o <= address_i & LINE_MASK;
            line_q    <= line_i;
            burst_o   <= line_i[BURST_W-1:0];
          end
        end
        RD: begin
          if (resp_i) begin
            line_o[int'(beat_idx)*BURST_W +: BURST_W] <= burst_i;
            if (beat_last) begin
              state  <= DONE;
              read_o <= 1'b0;
              resp_o <= 1'b1;
            end
          end
        end
        WR: begin
          // burst_o is registered, so it is preloaded with the beat after the one being accepted.
          if (resp_i) begin
            if (beat_last) begin
              state   <= DONE;
              write_o <= 1'b0;
              resp_o  <= 1'b1;
              burst_o <= '0;
            end else begin
              burst_o <= line_q[int'(beat_nxt)*BURST_W +: BURST_W];
            end
          end
        end
        DONE: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_line_adaptor.sv
// tb/tb_burst_line_adaptor.sv - randomized self-checking bench for burst_line_adaptor against a line/beat model
module tb_burst_line_adaptor;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int LINE_B  = LINE_W / 8;
  localparam int BEAT_B  = BURST_W / 8;

  logic               clk;
  logic               reset_n;
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [ADDR_W-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [ADDR_W-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  int n_checks = 0;
  int n_fails  = 0;

  burst_line_adaptor #(
    .LINE_W (LINE_W),
    .BURST_W(BURST_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .line_i   (line_i),
    .line_o   (line_o),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .resp_o   (resp_o),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .address_o(address_o),
    .read_o   (read_o),
    .write_o  (write_o),
    .resp_i   (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model: read burst address and the slot that receives the first beat.
  function automatic logic [ADDR_W-1:0] exp_rd_addr(input logic [ADDR_W-1:0] a);
`ifdef BURST_LINE_ADAPTOR_CWF_EN
    return a - (a % BEAT_B);
`else
    return a - (a % LINE_B);
`endif
  endfunction

  function automatic int exp_start(input logic [ADDR_W-1:0] a);
`ifdef BURST_LINE_ADAPTOR_CWF_EN
    return int'((a % LINE_B) / BEAT_B);
`else
    return 0;
`endif
  endfunction

  // beats holds the beats in arrival order, beat n in bits [n*BURST_W +: BURST_W].
  function automatic logic [LINE_W-1:0] exp_line(input logic [LINE_W-1:0] beats, input int start);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int n = 0; n < BEATS; n++) l[((start + n) % BEATS)*BURST_W +: BURST_W] = beats[n*BURST_W +: BURST_W];
    return l;
  endfunction

  function automatic logic gap_bit(input int cyc, input logic [31:0] pat, input int plen, input int gap_pct);
    if (plen > 0) return pat[cyc % plen];
    return ($urandom_range(99) >= gap_pct);
  endfunction

  task automatic do_read(input string tag, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] beats,
                         input int gap_pct, input logic [31:0] pat, input int plen);
    logic [LINE_W-1:0] want;
    int k;
    int cyc;
    logic r;
    want = exp_line(beats, exp_start(addr));
    read_i    = 1'b1;
    address_i = addr;
    step();
    check_eq({tag, "_addr"}, address_o, exp_rd_addr(addr));
    k = 0;
    cyc = 0;
    while (k < BEATS && cyc < 64) begin
      check_eq({tag, "_busy"}, {read_o, write_o, resp_o}, 3'b100);
      r = gap_bit(cyc, pat, plen, gap_pct);
      resp_i  = r;
      burst_i = r ? beats[k*BURST_W +: BURST_W] : {$urandom, $urandom};
      if (r) k++;
      step();
      cyc++;
    end
    if (k < BEATS) check_eq({tag, "_timeout"}, k, BEATS);
    resp_i  = 1'($urandom_range(1));
    burst_i = {$urandom, $urandom};
    check_eq({tag, "_done"}, {read_o, write_o, resp_o}, 3'b001);
    check_eq({tag, "_line"}, line_o, want);
    read_i = 1'b0;
    step();
    resp_i = 1'b0;
    check_eq({tag, "_idle"}, {read_o, write_o, resp_o}, 3'b000);
    check_eq({tag, "_hold"}, line_o, want);
  endtask

  task automatic do_write(input string tag, input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] line,
                          input int gap_pct, input logic [31:0] pat, input int plen, input int abort_at);
    int k;
    int cyc;
    logic r;
    write_i   = 1'b1;
    address_i = addr;
    line_i    = line;
    step();
    line_i = rand_line();
    check_eq({tag, "_addr"}, address_o, addr - (addr % LINE_B));
    k = 0;
    cyc = 0;
    while (k < BEATS && cyc < 64) begin
      check_eq({tag, "_busy"}, {read_o, write_o, resp_o}, 3'b010);
      check_eq({tag, "_beat"}, burst_o, line[k*BURST_W +: BURST_W]);
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_eq({tag, "_rst_flags"}, {read_o, write_o, resp_o}, 3'b000);
        check_eq({tag, "_rst_data"}, {burst_o, address_o}, '0);
        check_eq({tag, "_rst_line"}, line_o, '0);
        write_i = 1'b0;
        resp_i  = 1'b0;
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
          step();
          check_eq({tag, "_no_resp"}, {read_o, write_o, resp_o}, 3'b000);
        end
        return;
      end
      r = gap_bit(cyc, pat, plen, gap_pct);
      resp_i = r;
      if (r) k++;
      step();
      cyc++;
    end
    if (k < BEATS) check_eq({tag, "_timeout"}, k, BEATS);
    resp_i = 1'($urandom_range(1));
    check_eq({tag, "_done"}, {read_o, write_o, resp_o}, 3'b001);
    write_i = 1'b0;
    step();
    resp_i = 1'b0;
    check_eq({tag, "_idle"}, {read_o, write_o, resp_o}, 3'b000);
  endtask

  initial begin
    logic [LINE_W-1:0] beats;
    logic [LINE_W-1:0] line;
    reset_n   = 1'b0;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    step();
    step();
    check_eq("reset_flags", {read_o, write_o, resp_o}, 3'b000);
    check_eq("reset_data", {burst_o, address_o}, '0);
    check_eq("reset_line", line_o, '0);
    reset_n = 1'b1;
    resp_i  = 1'b1;
    step();
    check_eq("idle_resp_ignored", {read_o, write_o, resp_o}, 3'b000);
    resp_i = 1'b0;

    beats = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_read("rd_basic", 32'h1000, beats, 0, 32'h0, 0);

    line = {64'd4, 64'd3, 64'd2, 64'd1};
    do_write("wr_basic", 32'h2010, line, 0, 32'h0, 0, -1);

    do_read("rd_gaps", 32'h1000, beats, 0, 32'b1011001, 7);

    write_i = 1'b1;
    line_i  = rand_line();
    do_read("both_rd", 32'h40, rand_line(), 0, 32'h0, 0);
    do_write("both_wr", 32'h40, rand_line(), 0, 32'h0, 0, -1);

    do_write("wr_abort", 32'h3000, rand_line(), 0, 32'h0, 0, 2);
    do_read("rd_after_rst", 32'h3000, rand_line(), 0, 32'h0, 0);

    beats = {64'h4848_4848_4848_4848, 64'h4747_4747_4747_4747, 64'h4646_4646_4646_4646, 64'h4545_4545_4545_4545};
    do_read("rd_cwf", 32'h1018, beats, 0, 32'h0, 0);

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(1) == 1)
        do_read("rnd_rd", $urandom, rand_line(), $urandom_range(60), 32'h0, 0);
      else
        do_write("rnd_wr", $urandom, rand_line(), $urandom_range(60), 32'h0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
